// File: rtl/avr_fetch_unit_if.sv
// Fetch-stage bus: control-unit next-PC select, jump operand, program-memory
// address/data and the instruction handed to decode.
// Optional macro AVR_FETCH_INSTR_PC_EN adds instr_pc (address of cur_instr).
interface avr_fetch_unit_if;
  logic [2:0]  pc_src;
  logic [15:0] jmp;
  logic [15:0] prog_data;
  logic [15:0] prog_addr;
  logic [15:0] cur_instr;
`ifdef AVR_FETCH_INSTR_PC_EN
  logic [15:0] instr_pc;
`endif

  // Fetch unit side
  modport master (
    input  pc_src,
    input  jmp,
    input  prog_data,
    output prog_addr,
`ifdef AVR_FETCH_INSTR_PC_EN
    output instr_pc,
`endif
    output cur_instr
  );

  // Control unit / program memory side
  modport slave (
    output pc_src,
    output jmp,
    output prog_data,
    input  prog_addr,
`ifdef AVR_FETCH_INSTR_PC_EN
    input  instr_pc,
`endif
    input  cur_instr
  );
endinterface

// File: rtl/avr_fetch_unit.sv
// AVR instruction-fetch stage: PC register driving an async-read program
// memory, and an instruction register feeding decode.
// Optional macro AVR_FETCH_INSTR_PC_EN adds instr_pc tracking.
module avr_fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] NOP_INSTR    = 16'h0000
) (
  input logic               CLK,
  input logic               RST,
  avr_fetch_unit_if.master  bus
);

  localparam logic [2:0] SrcSeq   = 3'b000;
  localparam logic [2:0] SrcSkip  = 3'b001;
  localparam logic [2:0] SrcStall = 3'b010;
  localparam logic [2:0] SrcFlush = 3'b011;
  localparam logic [2:0] SrcRel   = 3'b100;
  localparam logic [2:0] SrcAbs   = 3'b101;

  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        load_data;
  logic        load_nop;

  // Next-PC selection and IR source decode; reserved codes hold like stall
  always_comb begin
    pc_d      = pc_q;
    load_data = 1'b0;
    load_nop  = 1'b0;
    case (bus.pc_src)
      SrcSeq: begin
        pc_d      = pc_q + 16'd1;
        load_data = 1'b1;
      end
      SrcSkip, SrcFlush: begin
        pc_d     = pc_q + 16'd1;
        load_nop = 1'b1;
      end
      SrcRel: begin
        // Jump instruction sits at PC-1, so PC+k lands on AVR's PC+1+k target
        pc_d     = pc_q + bus.jmp;
        load_nop = 1'b1;
      end
      SrcAbs: begin
        pc_d     = bus.jmp;
        load_nop = 1'b1;
      end
      SrcStall: pc_d = pc_q;
      default:  pc_d = pc_q;
    endcase
  end

  // IR takes the fetched word, a NOP bubble, or holds
  always_comb begin
    ir_d = ir_q;
    if (load_data) begin
      ir_d = bus.prog_data;
    end else if (load_nop) begin
      ir_d = NOP_INSTR;
    end
  end

  // PC and IR state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q <= RESET_VECTOR;
      ir_q <= NOP_INSTR;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  assign bus.prog_addr = pc_q;
  assign bus.cur_instr = ir_q;

`ifdef AVR_FETCH_INSTR_PC_EN
  logic [15:0] ipc_q, ipc_d;

  // Address of the word in IR; 16'hFFFF marks a bubble
  always_comb begin
    ipc_d = ipc_q;
    if (load_data) begin
      ipc_d = pc_q;
    end else if (load_nop) begin
      ipc_d = 16'hFFFF;
    end
  end

  // Instruction-address state, bubble marker on reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ipc_q <= 16'hFFFF;
    end else begin
      ipc_q <= ipc_d;
    end
  end

  assign bus.instr_pc = ipc_q;
`endif

endmodule

// File: tb/tb_avr_fetch_unit.sv
// Self-checking bench for avr_fetch_unit with a scoreboard of expected
// prog_addr / cur_instr (/ instr_pc) values; memory is pmem[i] = 16'hA000+i.
module tb_avr_fetch_unit;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic clk_run = 1'b0;

  avr_fetch_unit_if bus ();

  avr_fetch_unit dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Asynchronous-read program memory model
  assign bus.prog_data = 16'hA000 + bus.prog_addr;

  initial begin
    wait (clk_run);
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] ipc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Apply inputs and advance past one rising edge
  task automatic drive(input logic [2:0] src, input logic [15:0] j);
    bus.pc_src = src;
    bus.jmp    = j;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] i, input logic [15:0] p);
    exp_t e;
    e.addr  = a;
    e.instr = i;
    e.ipc   = p;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    exp_t e;
    bus.pc_src = 3'b101;
    bus.jmp    = 16'h1234;
    #3 RST = 1'b0;
    push(16'h0000, 16'h0000, 16'hFFFF);
    #1;
    e = sb.pop_front();
    n_checks++;
    if (bus.prog_addr !== e.addr)
      $display("FAIL reset_addr got %h want %h", bus.prog_addr, e.addr);
    else n_pass++;
    n_checks++;
    if (bus.cur_instr !== e.instr)
      $display("FAIL reset_instr got %h want %h", bus.cur_instr, e.instr);
    else n_pass++;
`ifdef AVR_FETCH_INSTR_PC_EN
    n_checks++;
    if (bus.instr_pc !== e.ipc)
      $display("FAIL reset_ipc got %h want %h", bus.instr_pc, e.ipc);
    else n_pass++;
`endif
    #2 RST = 1'b1;
    #2 clk_run = 1'b1;
  endtask

  // Runs one stimulus table through the scoreboard
  task automatic run_table(input string tag, input logic [2:0] src[],
                           input logic [15:0] j[], input logic [15:0] ea[],
                           input logic [15:0] ei[], input logic [15:0] ep[]);
    exp_t e;
    for (int k = 0; k < src.size(); k++) begin
      push(ea[k], ei[k], ep[k]);
      drive(src[k], j[k]);
      e = sb.pop_front();
      n_checks++;
      if (bus.prog_addr !== e.addr)
        $display("FAIL %s[%0d] prog_addr got %h want %h", tag, k, bus.prog_addr, e.addr);
      else n_pass++;
      n_checks++;
      if (bus.cur_instr !== e.instr)
        $display("FAIL %s[%0d] cur_instr got %h want %h", tag, k, bus.cur_instr, e.instr);
      else n_pass++;
`ifdef AVR_FETCH_INSTR_PC_EN
      n_checks++;
      if (bus.instr_pc !== e.ipc)
        $display("FAIL %s[%0d] instr_pc got %h want %h", tag, k, bus.instr_pc, e.ipc);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_sequential;
    run_table("seq", '{3'b000, 3'b000, 3'b000}, '{16'h0, 16'h0, 16'h0},
              '{16'h0001, 16'h0002, 16'h0003}, '{16'hA000, 16'hA001, 16'hA002},
              '{16'h0000, 16'h0001, 16'h0002});
  endtask

  task automatic test_stall;
    run_table("stall", '{3'b010, 3'b010, 3'b000}, '{16'h0, 16'h7777, 16'h0},
              '{16'h0003, 16'h0003, 16'h0004}, '{16'hA002, 16'hA002, 16'hA003},
              '{16'h0002, 16'h0002, 16'h0003});
  endtask

  task automatic test_flush;
    run_table("flush", '{3'b011, 3'b000}, '{16'h0, 16'h0},
              '{16'h0005, 16'h0006}, '{16'h0000, 16'hA005},
              '{16'hFFFF, 16'h0005});
  endtask

  task automatic test_abs_jump;
    run_table("abs", '{3'b101, 3'b000}, '{16'h0050, 16'h0},
              '{16'h0050, 16'h0051}, '{16'h0000, 16'hA050},
              '{16'hFFFF, 16'h0050});
  endtask

  task automatic test_rel_jump_wrap;
    run_table("rel", '{3'b100, 3'b100, 3'b000, 3'b001, 3'b101, 3'b000},
              '{16'h0005, 16'hFFFE, 16'h0, 16'h0, 16'hFFFF, 16'h0},
              '{16'h0056, 16'h0054, 16'h0055, 16'h0056, 16'hFFFF, 16'h0000},
              '{16'h0000, 16'h0000, 16'hA054, 16'h0000, 16'h0000, 16'h9FFF},
              '{16'hFFFF, 16'hFFFF, 16'h0054, 16'hFFFF, 16'hFFFF, 16'hFFFF});
  endtask

  task automatic test_reset_midstream;
    exp_t e;
    run_table("rjmp", '{3'b101}, '{16'h0050}, '{16'h0050}, '{16'h0000}, '{16'hFFFF});
    #2 RST = 1'b0;
    push(16'h0000, 16'h0000, 16'hFFFF);
    #1;
    e = sb.pop_front();
    n_checks++;
    if (bus.prog_addr !== e.addr)
      $display("FAIL midrst_addr got %h want %h", bus.prog_addr, e.addr);
    else n_pass++;
    n_checks++;
    if (bus.cur_instr !== e.instr)
      $display("FAIL midrst_instr got %h want %h", bus.cur_instr, e.instr);
    else n_pass++;
    // Held in reset across an edge regardless of pc_src
    run_table("rsthold", '{3'b000}, '{16'h0}, '{16'h0000}, '{16'h0000}, '{16'hFFFF});
    #3 RST = 1'b1;
    run_table("release", '{3'b000, 3'b110, 3'b111, 3'b000},
              '{16'h0, 16'h0, 16'h0, 16'h0},
              '{16'h0001, 16'h0001, 16'h0001, 16'h0002},
              '{16'hA000, 16'hA000, 16'hA000, 16'hA001},
              '{16'h0000, 16'h0000, 16'h0000, 16'h0001});
  endtask

  initial begin
    bus.pc_src = 3'b000;
    bus.jmp    = 16'h0000;
    test_reset();
    test_sequential();
    test_stall();
    test_flush();
    test_abs_jump();
    test_rel_jump_wrap();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
